// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer for the shared iterative multiplier/divider: MULT, DIV and DIVM (operands fetched from memory).
// Optional WAIT-state abort is enabled by defining MULDIV_TIMEOUT_EN.
module hilo_muldiv_ctrl #(
   parameter int MEM_LAT = 3,
   parameter int TIMEOUT = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [1:0]  op_sel,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic        op_done,
   output logic        div_zero,
   output logic        timeout,
   output logic        mem_rd,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   output logic        mul_start,
   output logic        div_start,
   output logic [31:0] opnd_a,
   output logic [31:0] opnd_b,
   input  logic        mul_done,
   input  logic [31:0] mul_hi,
   input  logic [31:0] mul_lo,
   input  logic        div_done,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [2:0] {S_IDLE, S_MEM_A, S_MEM_B, S_CHECK, S_LAUNCH, S_WAIT} state_t;
   typedef enum logic [1:0] {K_MULT, K_DIV, K_DIVM} kind_t;

   // One counter serves both the memory-read hold and the WAIT watchdog, so it is sized for the larger.
   localparam int CNT_MAX = (MEM_LAT > TIMEOUT) ? MEM_LAT : TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] MEM_LAST = CW'(MEM_LAT - 1);
`ifdef MULDIV_TIMEOUT_EN
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
`endif

   state_t        r_state;
   state_t        w_state_nxt;
   kind_t         r_kind;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_opnd_a;
   logic [31:0]   r_opnd_b;
   logic [31:0]   r_mem_addr;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;
   logic          r_op_done;
   logic          r_div_zero;
   logic          r_timeout;

   logic          w_accept;
   logic          w_mem_last;
   logic          w_core_done;
   logic          w_expired;

   assign w_accept    = op_valid && (op_sel != 2'b11);
   assign w_mem_last  = (r_cnt == MEM_LAST);
   assign w_core_done = (r_kind == K_MULT) ? mul_done : div_done;
`ifdef MULDIV_TIMEOUT_EN
   assign w_expired   = (r_cnt == WAIT_LAST);
`else
   assign w_expired   = 1'b0;
`endif

   // NOTE: next-state is assigned a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               unique case (op_sel)
                  2'b00:   w_state_nxt = S_LAUNCH;
                  2'b01:   w_state_nxt = S_CHECK;
                  default: w_state_nxt = S_MEM_A;
               endcase
            end
         end
         S_MEM_A:  if (w_mem_last) w_state_nxt = S_MEM_B;
         S_MEM_B:  if (w_mem_last) w_state_nxt = S_CHECK;
         S_CHECK:  w_state_nxt = (r_opnd_b == 32'd0) ? S_IDLE : S_LAUNCH;
         S_LAUNCH: w_state_nxt = S_WAIT;
         S_WAIT:   if (w_core_done || w_expired) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_kind     <= K_MULT;
         r_cnt      <= '0;
         r_opnd_a   <= '0;
         r_opnd_b   <= '0;
         r_mem_addr <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_op_done  <= 1'b0;
         r_div_zero <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_op_done  <= 1'b0;
         r_div_zero <= 1'b0;
         r_timeout  <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_opnd_a <= op_a;
                  r_opnd_b <= op_b;
                  r_cnt    <= '0;
                  unique case (op_sel)
                     2'b00:   r_kind <= K_MULT;
                     2'b01:   r_kind <= K_DIV;
                     default: begin
                        r_kind     <= K_DIVM;
                        r_mem_addr <= op_a;
                     end
                  endcase
               end
            end
            S_MEM_A: begin
               if (w_mem_last) begin
                  r_opnd_a   <= mem_rdata;
                  r_mem_addr <= r_opnd_b;
                  r_cnt      <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_MEM_B: begin
               if (w_mem_last) begin
                  r_opnd_b <= mem_rdata;
                  r_cnt    <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_CHECK:  if (r_opnd_b == 32'd0) r_div_zero <= 1'b1;
            S_LAUNCH: r_cnt <= '0;
            S_WAIT: begin
               // A done coinciding with watchdog expiry still commits the result.
               if (w_core_done) begin
                  if (r_kind == K_MULT) begin
                     r_hi <= mul_hi;
                     r_lo <= mul_lo;
                  end else begin
                     r_hi <= div_r;
                     r_lo <= div_q;
                  end
                  r_op_done <= 1'b1;
               end else if (w_expired) begin
                  r_timeout <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign mem_rd    = (r_state == S_MEM_A) || (r_state == S_MEM_B);
   assign mul_start = (r_state == S_LAUNCH) && (r_kind == K_MULT);
   assign div_start = (r_state == S_LAUNCH) && (r_kind != K_MULT);
   assign op_done   = r_op_done;
   assign div_zero  = r_div_zero;
   assign timeout   = r_timeout;
   assign mem_addr  = r_mem_addr;
   assign opnd_a    = r_opnd_a;
   assign opnd_b    = r_opnd_b;
   assign hi        = r_hi;
   assign lo        = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl with behavioural multiplier/divider cores and a two-word memory.
// Watchdog cases run only when MULDIV_TIMEOUT_EN is defined.
module tb_hilo_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [1:0]  op_sel;
   logic [31:0] op_a, op_b;
   logic        busy, op_done, div_zero, timeout, mem_rd;
   logic [31:0] mem_addr, mem_rdata;
   logic        mul_start, div_start;
   logic [31:0] opnd_a, opnd_b;
   logic        mul_done, div_done;
   logic [31:0] mul_hi, mul_lo, div_q, div_r;
   logic [31:0] hi, lo;

   localparam logic [1:0] SEL_MULT = 2'b00, SEL_DIV = 2'b01, SEL_DIVM = 2'b10, SEL_RSV = 2'b11;

   hilo_muldiv_ctrl #(.MEM_LAT(3), .TIMEOUT(40)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_sel(op_sel), .op_a(op_a), .op_b(op_b),
      .busy(busy), .op_done(op_done), .div_zero(div_zero), .timeout(timeout),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .mul_start(mul_start), .div_start(div_start), .opnd_a(opnd_a), .opnd_b(opnd_b),
      .mul_done(mul_done), .mul_hi(mul_hi), .mul_lo(mul_lo),
      .div_done(div_done), .div_q(div_q), .div_r(div_r), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   assign mem_rdata = (mem_addr == 32'h40) ? 32'd50 :
                      (mem_addr == 32'h44) ? 32'd5  : 32'hDEAD_BEEF;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Event monitor: only ever increments, tests compare before/after snapshots.
   int n_mul_start = 0, n_div_start = 0, n_mem_rd = 0, n_rd_40 = 0, n_rd_44 = 0;
   int n_op_done = 0, n_div_zero = 0, n_timeout = 0, n_busy = 0;
   logic [31:0] start_a = '0, start_b = '0;

   always @(posedge clk) begin
      if (mul_start) n_mul_start++;
      if (div_start) begin
         n_div_start++;
         start_a = opnd_a;
         start_b = opnd_b;
      end
      if (mem_rd) begin
         n_mem_rd++;
         if (mem_addr == 32'h40) n_rd_40++;
         if (mem_addr == 32'h44) n_rd_44++;
      end
      if (op_done)  n_op_done++;
      if (div_zero) n_div_zero++;
      if (timeout)  n_timeout++;
      if (busy)     n_busy++;
   end

   // Core model: core_lat edges after the start strobe is seen, the launched core raises done for one cycle.
   int   core_lat = 10;
   logic core_en  = 1'b1;
   logic stray_en = 1'b0;

   initial begin
      logic        is_mul;
      logic [31:0] a, b;
      mul_done = 1'b0; div_done = 1'b0;
      mul_hi = '0; mul_lo = '0; div_q = '0; div_r = '0;
      forever begin
         @(posedge clk);
         if ((mul_start || div_start) && !reset) begin
            is_mul = mul_start;
            a = opnd_a;
            b = opnd_b;
            for (int k = 1; k < core_lat; k++) begin
               @(posedge clk);
               #1;
               mul_done = 1'b0;
               div_done = 1'b0;
               if (stray_en && k == 3) begin
                  if (is_mul) begin
                     div_done = 1'b1; div_q = 32'hBAD0_BAD0; div_r = 32'h0BAD_0BAD;
                  end else begin
                     mul_done = 1'b1; mul_hi = 32'hBAD1_BAD1; mul_lo = 32'h1BAD_1BAD;
                  end
               end
            end
            if (core_en) begin
               if (is_mul) begin
                  {mul_hi, mul_lo} = {32'd0, a} * {32'd0, b};
                  mul_done = 1'b1;
               end else begin
                  div_q = a / b;
                  div_r = a % b;
                  div_done = 1'b1;
               end
            end
            @(posedge clk);
            #1;
            mul_done = 1'b0;
            div_done = 1'b0;
         end
      end
   end

   task automatic issue(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
      op_sel = sel; op_a = a; op_b = b; op_valid = 1'b1;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int cyc = 0;
      while (busy && cyc < 500) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (busy) check({tag, "_wait_bound"}, 64'(busy), 64'd0);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   int s_mul, s_div, s_done, s_dz, s_to, s_busy, s_rd;

   task automatic snap();
      s_mul = n_mul_start; s_div = n_div_start; s_done = n_op_done;
      s_dz = n_div_zero; s_to = n_timeout; s_busy = n_busy; s_rd = n_mem_rd;
   endtask

   initial begin
      reset = 1'b1; op_valid = 1'b0; op_sel = '0; op_a = '0; op_b = '0;
      step(3);
      reset = 1'b0;

      // Reset state and quiet idle
      step(5);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_opnd_a", 64'(opnd_a), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_no_strobes", 64'(n_mul_start + n_div_start + n_mem_rd), 64'd0);

      // MULT 0x10000 * 0x10000, stray div_done and an ignored request while busy
      core_lat = 32; stray_en = 1'b1;
      snap();
      issue(SEL_MULT, 32'h0001_0000, 32'h0001_0000);
      step(4);
      issue(SEL_DIV, 32'd9, 32'd3);
      check("busy_ignore_opnd_a", 64'(opnd_a), 64'h1_0000);
      check("busy_ignore_opnd_b", 64'(opnd_b), 64'h1_0000);
      wait_idle("mult1");
      check("mult1_op_done", 64'(op_done), 64'd1);
      check("mult1_hi", 64'(hi), 64'd1);
      check("mult1_lo", 64'(lo), 64'd0);
      check("mult1_busy_long", 64'(n_busy - s_busy >= 33), 64'd1);
      step(3);
      check("mult1_one_start", 64'(n_mul_start - s_mul), 64'd1);
      check("mult1_no_div_start", 64'(n_div_start - s_div), 64'd0);
      check("mult1_one_done", 64'(n_op_done - s_done), 64'd1);
      check("busy_ignore_idle", 64'(busy), 64'd0);
      stray_en = 1'b0;

      // DIV 100 / 7, stray mul_done during the wait
      core_lat = 10; stray_en = 1'b1;
      snap();
      issue(SEL_DIV, 32'd100, 32'd7);
      wait_idle("div1");
      check("div1_op_done", 64'(op_done), 64'd1);
      check("div1_lo_q", 64'(lo), 64'd14);
      check("div1_hi_r", 64'(hi), 64'd2);
      check("div1_start_opnds", {start_a, start_b}, {32'd100, 32'd7});
      step(1);
      check("div1_one_start", 64'(n_div_start - s_div), 64'd1);
      check("div1_no_mul_start", 64'(n_mul_start - s_mul), 64'd0);
      check("div1_one_done", 64'(n_op_done - s_done), 64'd1);
      stray_en = 1'b0;

      // DIV by zero keeps hi/lo
      snap();
      issue(SEL_DIV, 32'd55, 32'd0);
      wait_idle("dz");
      check("dz_pulse", 64'(div_zero), 64'd1);
      check("dz_hi_kept", 64'(hi), 64'd2);
      check("dz_lo_kept", 64'(lo), 64'd14);
      step(1);
      check("dz_no_start", 64'(n_div_start - s_div), 64'd0);
      check("dz_one_pulse", 64'(n_div_zero - s_dz), 64'd1);
      check("dz_no_op_done", 64'(n_op_done - s_done), 64'd0);

      // DIVM from 0x40 / 0x44 (50 / 5)
      snap();
      n_rd_40 = 0; n_rd_44 = 0;
      issue(SEL_DIVM, 32'h40, 32'h44);
      wait_idle("divm");
      check("divm_op_done", 64'(op_done), 64'd1);
      check("divm_lo", 64'(lo), 64'd10);
      check("divm_hi", 64'(hi), 64'd0);
      check("divm_rd_a", 64'(n_rd_40), 64'd3);
      check("divm_rd_b", 64'(n_rd_44), 64'd3);
      check("divm_start_opnds", {start_a, start_b}, {32'd50, 32'd5});
      step(1);
      check("divm_rd_total", 64'(n_mem_rd - s_rd), 64'd6);
      check("divm_one_start", 64'(n_div_start - s_div), 64'd1);

      // Reserved op_sel is ignored
      snap();
      issue(SEL_RSV, 32'd1, 32'd2);
      check("rsv_busy", 64'(busy), 64'd0);
      step(3);
      check("rsv_no_activity", 64'(n_mul_start + n_div_start + n_busy + n_mem_rd - s_mul - s_div - s_busy - s_rd), 64'd0);
      check("rsv_lo_kept", 64'(lo), 64'd10);

      // MULT 0xFFFFFFFF * 2
      core_lat = 5;
      issue(SEL_MULT, 32'hFFFF_FFFF, 32'd2);
      wait_idle("mult2");
      check("mult2_hi", 64'(hi), 64'd1);
      check("mult2_lo", 64'(lo), 64'hFFFF_FFFE);

      // Done arriving in the 40th WAIT cycle
      core_lat = 40;
      snap();
      issue(SEL_MULT, 32'd6, 32'd7);
      wait_idle("mult40");
      check("mult40_op_done", 64'(op_done), 64'd1);
      check("mult40_no_timeout", 64'(timeout), 64'd0);
      check("mult40_lo", 64'(lo), 64'd42);
      check("mult40_hi", 64'(hi), 64'd0);

`ifdef MULDIV_TIMEOUT_EN
      // Core never answers: watchdog aborts after 40 WAIT cycles
      core_en = 1'b0;
      snap();
      issue(SEL_MULT, 32'd3, 32'd3);
      wait_idle("to");
      check("to_pulse", 64'(timeout), 64'd1);
      check("to_busy_cycles", 64'(n_busy - s_busy), 64'd41);
      check("to_lo_kept", 64'(lo), 64'd42);
      step(1);
      check("to_one_pulse", 64'(n_timeout - s_to), 64'd1);
      check("to_no_op_done", 64'(n_op_done - s_done), 64'd0);
      core_en = 1'b1;
      step(45);
`else
      check("no_timeout_ever", 64'(n_timeout), 64'd0);
`endif

      // Reset in the middle of WAIT; the late mul_done must be ignored
      core_lat = 20;
      issue(SEL_MULT, 32'd3, 32'd5);
      step(8);
      check("midrst_busy_before", 64'(busy), 64'd1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check("midrst_idle", 64'(busy), 64'd0);
      check("midrst_hi_cleared", 64'(hi), 64'd0);
      snap();
      step(25);
      check("midrst_late_done_ignored", 64'(n_op_done - s_done), 64'd0);
      check("midrst_lo", 64'(lo), 64'd0);
      check("midrst_busy_after", 64'(busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
      $finish;
   end

endmodule
